// File: rtl/alt_ddrx_sched_pkg.sv
// Shared definitions for the DDR2 read/write command scheduler.
//
// Contents:
//   sched_dir_e : direction of a command grant (NONE / RD / WR)
//   sched_max   : helper returning the larger of two unsigned values
package alt_ddrx_sched_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_RD   = 2'd1,
        DIR_WR   = 2'd2
    } sched_dir_e;

    function automatic int unsigned sched_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alt_ddrx_sched_down_cnt.sv
// Saturating load/decrement counter used for command spacing.
//
// Ports:
//   ctl_clk   : clock, rising edge
//   ctl_reset : synchronous active-high reset, clears the count
//   load      : load load_val this cycle (wins over decrement)
//   load_val  : value to load
//   cnt       : current count; decrements by one per cycle, holds at 0
module alt_ddrx_sched_down_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             ctl_clk,
    input  logic             ctl_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

endmodule

// File: rtl/alt_ddrx_ddr2_rdwr_sched.sv
// DDR2 read/write command scheduler.
//
// Arbitrates between a read and a write requester, enforcing the minimum
// same-direction command spacing (CMD_GAP) and the configurable bus
// turnaround times, with a starvation limit on same-direction streaks.
//
// Ports:
//   ctl_clk       : clock, rising edge
//   ctl_reset     : synchronous active-high reset
//   rd_req/wr_req : requester has a command pending (held until acked)
//   sched_stall   : blocks all grants; timers keep running
//   cfg_rd_to_wr  : minimum read-to-write spacing, ctl_clk cycles (0 = CMD_GAP)
//   cfg_wr_to_rd  : minimum write-to-read spacing, ctl_clk cycles (0 = CMD_GAP)
//   rd_ack/wr_ack : grant this cycle (combinational, at most one)
//   do_read/write : issue strobes to the ODT generator, mirror the acks
//   last_dir      : direction of the most recent grant
//
// last_dir states:
//   DIR_NONE | no grant since reset; either direction needs only gap_cnt==0
//   DIR_RD   | last grant was a read; a write also waits for turn_cnt==0
//   DIR_WR   | last grant was a write; a read also waits for turn_cnt==0
module alt_ddrx_ddr2_rdwr_sched
    import alt_ddrx_sched_pkg::*;
#(
    parameter int DWIDTH_RATIO       = 2,
    parameter int MEMORY_BURSTLENGTH = 8,
    parameter int TURN_BUS_WIDTH     = 4,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                      ctl_clk,
    input  logic                      ctl_reset,
    input  logic                      rd_req,
    input  logic                      wr_req,
    input  logic                      sched_stall,
    input  logic [TURN_BUS_WIDTH-1:0] cfg_rd_to_wr,
    input  logic [TURN_BUS_WIDTH-1:0] cfg_wr_to_rd,
    output logic                      rd_ack,
    output logic                      wr_ack,
    output logic                      do_read,
    output logic                      do_write,
    output logic [1:0]                last_dir
);

    localparam int CMD_GAP_RAW = MEMORY_BURSTLENGTH / DWIDTH_RATIO;
    localparam int CMD_GAP     = (CMD_GAP_RAW < 1) ? 1 : CMD_GAP_RAW;

    // Counter must hold both the widest cfg value and CMD_GAP.
    localparam int CNT_W = int'(sched_max(TURN_BUS_WIDTH, $clog2(CMD_GAP + 1)));
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    GAP_W      = CNT_W'(CMD_GAP);
    localparam logic [CNT_W-1:0]    GAP_LOAD   = CNT_W'(CMD_GAP - 1);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    sched_dir_e          last_dir_q;
    logic [STREAK_W-1:0] streak_q;

    logic [CNT_W-1:0]    gap_cnt;
    logic [CNT_W-1:0]    turn_cnt;
    logic [CNT_W-1:0]    rd_to_wr_ext;
    logic [CNT_W-1:0]    wr_to_rd_ext;
    logic [CNT_W-1:0]    rd_turn_load;
    logic [CNT_W-1:0]    wr_turn_load;
    logic [CNT_W-1:0]    turn_load_val;

    logic gap_done;
    logic turn_done;
    logic rd_elig;
    logic wr_elig;
    logic starved;
    logic grant_rd;
    logic grant_wr;
    logic any_ack;

    // Turnaround reload values. Taking the max against CMD_GAP also makes a
    // cfg value of 0 behave as CMD_GAP.
    assign rd_to_wr_ext = CNT_W'(cfg_rd_to_wr);
    assign wr_to_rd_ext = CNT_W'(cfg_wr_to_rd);
    assign rd_turn_load = ((rd_to_wr_ext > GAP_W) ? rd_to_wr_ext : GAP_W) - CNT_ONE;
    assign wr_turn_load = ((wr_to_rd_ext > GAP_W) ? wr_to_rd_ext : GAP_W) - CNT_ONE;

    assign gap_done  = (gap_cnt == '0);
    assign turn_done = (turn_cnt == '0);

    // Turnaround only matters when switching direction.
    assign rd_elig = gap_done && ((last_dir_q != DIR_WR) || turn_done);
    assign wr_elig = gap_done && ((last_dir_q != DIR_RD) || turn_done);

    // Streak at the limit with the other side waiting: the current direction
    // is held off until the other side has been served.
    assign starved = rd_req && wr_req && (streak_q == STREAK_MAX);

    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        unique case (last_dir_q)
            DIR_RD: begin
                grant_rd = rd_req && rd_elig && !starved;
                grant_wr = wr_req && wr_elig && !grant_rd;
            end
            DIR_WR: begin
                grant_wr = wr_req && wr_elig && !starved;
                grant_rd = rd_req && rd_elig && !grant_wr;
            end
            default: begin
                grant_rd = rd_req && rd_elig;
                grant_wr = wr_req && wr_elig && !grant_rd;
            end
        endcase
    end

    assign rd_ack   = grant_rd && !sched_stall && !ctl_reset;
    assign wr_ack   = grant_wr && !sched_stall && !ctl_reset;
    assign do_read  = rd_ack;
    assign do_write = wr_ack;
    assign any_ack  = rd_ack || wr_ack;
    assign last_dir = last_dir_q;

    assign turn_load_val = rd_ack ? rd_turn_load : wr_turn_load;

    alt_ddrx_sched_down_cnt #(
        .WIDTH (CNT_W)
    ) u_gap_cnt (
        .ctl_clk   (ctl_clk),
        .ctl_reset (ctl_reset),
        .load      (any_ack),
        .load_val  (GAP_LOAD),
        .cnt       (gap_cnt)
    );

    alt_ddrx_sched_down_cnt #(
        .WIDTH (CNT_W)
    ) u_turn_cnt (
        .ctl_clk   (ctl_clk),
        .ctl_reset (ctl_reset),
        .load      (any_ack),
        .load_val  (turn_load_val),
        .cnt       (turn_cnt)
    );

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            last_dir_q <= DIR_NONE;
            streak_q   <= '0;
        end else if (rd_ack) begin
            last_dir_q <= DIR_RD;
            if (last_dir_q != DIR_RD) begin
                streak_q <= STREAK_ONE;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + STREAK_ONE;
            end
        end else if (wr_ack) begin
            last_dir_q <= DIR_WR;
            if (last_dir_q != DIR_WR) begin
                streak_q <= STREAK_ONE;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + STREAK_ONE;
            end
        end
    end

endmodule
